ovr_dff_bank: RTL and testbench
===============================

Name: ovr_dff_bank

Overview:
- Parametrised bank of CHANNELS independent WIDTH-bit D registers.
- Each channel has a synchronous override path: force-ones, force-zeros, force-to-value or freeze.
- Release semantics: after override drops, q keeps the forced value until the channel's next enabled capture, then resumes tracking d.
- Used as the forceable state element for debug/test-mode control registers in the sim library.

Parameters:
WIDTH, 8, bits per channel
CHANNELS, 4, number of independent channels
RESET_VAL, 0, value loaded into every channel's q on reset (WIDTH bits)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
en  in  CHANNELS  per-channel capture enable
d  in  CHANNELS*WIDTH  per-channel data; channel i at bits [i*WIDTH +: WIDTH]
ovr_req  in  CHANNELS  per-channel override request (level)
ovr_mode  in  2*CHANNELS  per-channel mode, bits [2i+:2]: 00 force-ones, 01 force-zeros, 10 force-ovr_val, 11 freeze
ovr_val  in  CHANNELS*WIDTH  per-channel force value, used in mode 10
q  out  CHANNELS*WIDTH  registered per-channel output
ovr_active  out  CHANNELS  channel is in FORCED
ovr_hold  out  CHANNELS  channel is in HOLD (released, awaiting capture)

Behaviour:
- Reset: one clock, synchronous, active-high; polarity and synchronicity are fixed. rst=1 at an edge sets every q=RESET_VAL, every FSM=NORMAL, ovr_active=0, ovr_hold=0. rst overrides ovr_req and en.
- Each channel has its own 3-state FSM: NORMAL, FORCED, HOLD. Channels never interact.
- NORMAL:
  - en=1 -> q<=d.
  - en=0 -> q holds.
  - ovr_req=1 -> next state FORCED. q takes the forced value at this same edge; ovr_req has priority over en.
- FORCED:
  - Each edge, q <= forced value per the ovr_mode sampled at that edge: all-ones, all-zeros, ovr_val, or q (freeze).
  - Mode or ovr_val changes take effect at the next edge.
  - en and d are ignored.
  - ovr_req=0 -> next state HOLD; q keeps its current value at that edge (last forced value).
- HOLD:
  - q holds the last forced value.
  - ovr_req=1 -> FORCED, with the forced value applied at that edge.
  - else en=1 -> q<=d, next state NORMAL.
  - else stay in HOLD.
  - ovr_req has priority over en.
- Latency:
  - ovr_req to forced q: 1 edge.
  - en/d to q: 1 edge.
  - All outputs are registered; no combinational input-to-output paths.
- ovr_active=1 iff state FORCED; ovr_hold=1 iff state HOLD. Both are registered with the state.
- Boundaries:
  - Freeze entered from NORMAL captures the current q (not d).
  - A one-cycle ovr_req pulse gives FORCED for 1 cycle, then HOLD.
  - rst asserted mid-FORCED or mid-HOLD returns the channel to NORMAL with q=RESET_VAL.
  - ovr_mode values are fully decoded; there are no illegal codes.

Optional Feature:
- Macro OVR_DFF_CNT_EN.
- Defined:
  - Adds output ovr_cnt, CHANNELS*16 bits: a per-channel saturating count of edges spent in FORCED.
  - Cleared to 0 on rst and on the NORMAL->FORCED transition.
  - Not cleared on a HOLD->FORCED transition; accumulates instead.
  - Saturates at 16'hFFFF.
  - Holds its value in HOLD and NORMAL.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst=1 for 1 edge with en=all-ones, ovr_req=all-ones -> all q=RESET_VAL (0x00), ovr_active=0, ovr_hold=0.
- Normal capture: ch0 en=1, d=0x5A -> q0=0x5A next edge; en=0, d=0x33 -> q0 stays 0x5A.
- Force/release:
  - ch1 q=0x12, ovr_req=1 mode 00 -> q1=0xFF and ovr_active1=1 after 1 edge.
  - Drop ovr_req with en=0 -> q1 stays 0xFF, ovr_hold1=1 over 5 edges.
  - en=1, d=0x34 -> q1=0x34, state NORMAL.
- Modes and priority:
  - ch2 mode 10, ovr_val=0xA5, en=1, d=0x0F -> q2=0xA5.
  - Switch to mode 11 -> q2 frozen at 0xA5.
  - Switch to mode 01 -> q2=0x00 next edge.
- Isolation and mid-op reset:
  - Force ch3 while ch0 captures -> ch0 unaffected.
  - Assert rst while ch3 in HOLD -> q3=0x00, ovr_hold3=0.
- OVR_DFF_CNT_EN:
  - Force ch0 for 7 edges, release, then re-force from HOLD for 3 -> ovr_cnt0=10.
  - Return to NORMAL, then force again -> ovr_cnt0 restarts at 1.

Source files
------------

// File: rtl/ovr_dff_bank.sv
// rtl/ovr_dff_bank.sv - bank of forceable D registers with per-channel override/release FSM
//
// Purpose:
//   CHANNELS independent WIDTH-bit registers. Each channel is either tracking d
//   (NORMAL), being overridden (FORCED), or holding its last forced value after
//   release (HOLD) until the next enabled capture.
//
// Optional feature:
//   OVR_DFF_CNT_EN - when defined, adds ovr_cnt, a per-channel 16-bit saturating
//   count of edges spent in FORCED.
//
// Ports:
//   clk        in   clock, all state updates on rising edge
//   rst        in   synchronous active-high reset
//   en         in   [CHANNELS]        per-channel capture enable
//   d          in   [CHANNELS*WIDTH]  per-channel data, channel i at [i*WIDTH +: WIDTH]
//   ovr_req    in   [CHANNELS]        per-channel override request (level)
//   ovr_mode   in   [2*CHANNELS]      [2i+:2]: 00 ones, 01 zeros, 10 ovr_val, 11 freeze
//   ovr_val    in   [CHANNELS*WIDTH]  per-channel force value for mode 10
//   q          out  [CHANNELS*WIDTH]  registered per-channel output
//   ovr_active out  [CHANNELS]        channel in FORCED
//   ovr_hold   out  [CHANNELS]        channel in HOLD
//   ovr_cnt    out  [CHANNELS*16]     (OVR_DFF_CNT_EN only) edges spent in FORCED

module ovr_dff_bank #(
    parameter int                 WIDTH     = 8,
    parameter int                 CHANNELS  = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           en,
    input  logic [CHANNELS*WIDTH-1:0]     d,
    input  logic [CHANNELS-1:0]           ovr_req,
    input  logic [2*CHANNELS-1:0]         ovr_mode,
    input  logic [CHANNELS*WIDTH-1:0]     ovr_val,
    output logic [CHANNELS*WIDTH-1:0]     q,
    output logic [CHANNELS-1:0]           ovr_active,
    output logic [CHANNELS-1:0]           ovr_hold
`ifdef OVR_DFF_CNT_EN
    ,
    output logic [CHANNELS*16-1:0]        ovr_cnt
`endif
);

    localparam logic [1:0] ST_NORMAL = 2'd0;
    localparam logic [1:0] ST_FORCED = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [1:0] MODE_ONES   = 2'b00;
    localparam logic [1:0] MODE_ZEROS  = 2'b01;
    localparam logic [1:0] MODE_VALUE  = 2'b10;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]       state;
        logic [WIDTH-1:0] q_r;
        logic [WIDTH-1:0] force_val;
        logic [1:0]       mode_i;
        logic             req_i;

        assign mode_i = ovr_mode[2*i +: 2];
        assign req_i  = ovr_req[i];

        // Freeze (mode 11) re-loads q itself, so entering freeze from NORMAL
        // captures the current q rather than d.
        always_comb begin
            force_val = q_r;
            case (mode_i)
                MODE_ONES:  force_val = '1;
                MODE_ZEROS: force_val = '0;
                MODE_VALUE: force_val = ovr_val[i*WIDTH +: WIDTH];
                default:    force_val = q_r;
            endcase
        end

        // The unused encoding 2'd3 falls into the default arm and behaves as NORMAL.
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_NORMAL;
                q_r   <= RESET_VAL;
            end else begin
                case (state)
                    ST_FORCED: begin
                        if (req_i) begin
                            q_r <= force_val;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (req_i) begin
                            state <= ST_FORCED;
                            q_r   <= force_val;
                        end else if (en[i]) begin
                            state <= ST_NORMAL;
                            q_r   <= d[i*WIDTH +: WIDTH];
                        end
                    end
                    default: begin
                        if (req_i) begin
                            state <= ST_FORCED;
                            q_r   <= force_val;
                        end else if (en[i]) begin
                            q_r <= d[i*WIDTH +: WIDTH];
                        end
                    end
                endcase
            end
        end

        assign q[i*WIDTH +: WIDTH] = q_r;
        assign ovr_active[i]       = (state == ST_FORCED);
        assign ovr_hold[i]         = (state == ST_HOLD);

`ifdef OVR_DFF_CNT_EN
        logic [15:0] cnt;

        // Counts edges at which the channel is already FORCED. A fresh override
        // from NORMAL starts over; re-forcing from HOLD keeps accumulating.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (state != ST_FORCED && state != ST_HOLD && req_i) begin
                cnt <= '0;
            end else if (state == ST_FORCED && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign ovr_cnt[i*16 +: 16] = cnt;
`endif
    end

endmodule

// File: tb/tb_ovr_dff_bank.sv
// tb/tb_ovr_dff_bank.sv - directed self-checking bench for ovr_dff_bank
module tb_ovr_dff_bank;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS*WIDTH-1:0] d;
    logic [CHANNELS-1:0]       ovr_req;
    logic [2*CHANNELS-1:0]     ovr_mode;
    logic [CHANNELS*WIDTH-1:0] ovr_val;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [CHANNELS-1:0]       ovr_active;
    logic [CHANNELS-1:0]       ovr_hold;
`ifdef OVR_DFF_CNT_EN
    logic [CHANNELS*16-1:0]    ovr_cnt;
`endif

    int errors = 0;
    int checks = 0;

    ovr_dff_bank #(
        .WIDTH     (WIDTH),
        .CHANNELS  (CHANNELS),
        .RESET_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .d          (d),
        .ovr_req    (ovr_req),
        .ovr_mode   (ovr_mode),
        .ovr_val    (ovr_val),
        .q          (q),
        .ovr_active (ovr_active),
        .ovr_hold   (ovr_hold)
`ifdef OVR_DFF_CNT_EN
        ,
        .ovr_cnt    (ovr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] qch(input int c);
        return q[c*WIDTH +: WIDTH];
    endfunction

    task automatic test_reset();
        en       = '1;
        ovr_req  = '1;
        ovr_mode = '0;
        rst      = 1'b1;
        step();
        rst     = 1'b0;
        en      = '0;
        ovr_req = '0;
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL reset_q: got %h expected %h", q, 32'h0);
        end
        checks++;
        if (ovr_active !== 4'b0000) begin
            errors++;
            $display("FAIL reset_active: got %b expected %b", ovr_active, 4'b0000);
        end
        checks++;
        if (ovr_hold !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", ovr_hold, 4'b0000);
        end
    endtask

    task automatic test_normal_capture();
        en[0] = 1'b1;
        d[7:0] = 8'h5A;
        step();
        checks++;
        if (qch(0) !== 8'h5A) begin
            errors++;
            $display("FAIL capture_q0: got %h expected %h", qch(0), 8'h5A);
        end
        en[0] = 1'b0;
        d[7:0] = 8'h33;
        step();
        checks++;
        if (qch(0) !== 8'h5A) begin
            errors++;
            $display("FAIL hold_q0: got %h expected %h", qch(0), 8'h5A);
        end
    endtask

    task automatic test_force_release();
        en[1] = 1'b1;
        d[15:8] = 8'h12;
        step();
        en[1] = 1'b0;
        ovr_req[1] = 1'b1;
        ovr_mode[3:2] = 2'b00;
        step();
        checks++;
        if (qch(1) !== 8'hFF || ovr_active[1] !== 1'b1) begin
            errors++;
            $display("FAIL force_ones_q1: got q=%h act=%b expected q=ff act=1", qch(1), ovr_active[1]);
        end
        ovr_req[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (qch(1) !== 8'hFF || ovr_hold[1] !== 1'b1 || ovr_active[1] !== 1'b0) begin
                errors++;
                $display("FAIL hold_q1[%0d]: got q=%h hold=%b act=%b expected q=ff hold=1 act=0",
                         k, qch(1), ovr_hold[1], ovr_active[1]);
            end
        end
        en[1] = 1'b1;
        d[15:8] = 8'h34;
        step();
        en[1] = 1'b0;
        checks++;
        if (qch(1) !== 8'h34 || ovr_hold[1] !== 1'b0 || ovr_active[1] !== 1'b0) begin
            errors++;
            $display("FAIL release_capture_q1: got q=%h hold=%b act=%b expected q=34 hold=0 act=0",
                     qch(1), ovr_hold[1], ovr_active[1]);
        end
    endtask

    task automatic test_modes_priority();
        ovr_mode[5:4] = 2'b10;
        ovr_val[23:16] = 8'hA5;
        en[2] = 1'b1;
        d[23:16] = 8'h0F;
        ovr_req[2] = 1'b1;
        step();
        checks++;
        if (qch(2) !== 8'hA5 || ovr_active[2] !== 1'b1) begin
            errors++;
            $display("FAIL force_val_q2: got q=%h act=%b expected q=a5 act=1", qch(2), ovr_active[2]);
        end
        ovr_mode[5:4] = 2'b11;
        ovr_val[23:16] = 8'h3C;
        step();
        checks++;
        if (qch(2) !== 8'hA5) begin
            errors++;
            $display("FAIL freeze_q2: got %h expected %h", qch(2), 8'hA5);
        end
        step();
        checks++;
        if (qch(2) !== 8'hA5) begin
            errors++;
            $display("FAIL freeze2_q2: got %h expected %h", qch(2), 8'hA5);
        end
        ovr_mode[5:4] = 2'b01;
        step();
        checks++;
        if (qch(2) !== 8'h00) begin
            errors++;
            $display("FAIL force_zeros_q2: got %h expected %h", qch(2), 8'h00);
        end
        ovr_req[2] = 1'b0;
        en[2] = 1'b0;
        step();
        en[2] = 1'b1;
        d[23:16] = 8'h66;
        step();
        en[2] = 1'b0;
        checks++;
        if (qch(2) !== 8'h66 || ovr_hold[2] !== 1'b0) begin
            errors++;
            $display("FAIL recapture_q2: got q=%h hold=%b expected q=66 hold=0", qch(2), ovr_hold[2]);
        end
    endtask

    task automatic test_freeze_from_normal();
        en[0] = 1'b1;
        d[7:0] = 8'h99;
        step();
        d[7:0] = 8'h11;
        ovr_mode[1:0] = 2'b11;
        ovr_req[0] = 1'b1;
        step();
        checks++;
        if (qch(0) !== 8'h99 || ovr_active[0] !== 1'b1) begin
            errors++;
            $display("FAIL freeze_entry_q0: got q=%h act=%b expected q=99 act=1", qch(0), ovr_active[0]);
        end
        ovr_req[0] = 1'b0;
        step();
        step();
        en[0] = 1'b0;
        checks++;
        if (qch(0) !== 8'h11 || ovr_hold[0] !== 1'b0) begin
            errors++;
            $display("FAIL freeze_exit_q0: got q=%h hold=%b expected q=11 hold=0", qch(0), ovr_hold[0]);
        end
    endtask

    task automatic test_pulse();
        ovr_mode[3:2] = 2'b10;
        ovr_val[15:8] = 8'h77;
        ovr_req[1] = 1'b1;
        step();
        ovr_req[1] = 1'b0;
        checks++;
        if (ovr_active[1] !== 1'b1 || qch(1) !== 8'h77) begin
            errors++;
            $display("FAIL pulse_forced_q1: got q=%h act=%b expected q=77 act=1", qch(1), ovr_active[1]);
        end
        step();
        checks++;
        if (ovr_active[1] !== 1'b0 || ovr_hold[1] !== 1'b1 || qch(1) !== 8'h77) begin
            errors++;
            $display("FAIL pulse_hold_q1: got q=%h act=%b hold=%b expected q=77 act=0 hold=1",
                     qch(1), ovr_active[1], ovr_hold[1]);
        end
    endtask

    task automatic test_isolation_reset();
        ovr_mode[7:6] = 2'b00;
        ovr_req[3] = 1'b1;
        en[0] = 1'b1;
        d[7:0] = 8'hC3;
        step();
        en[0] = 1'b0;
        checks++;
        if (qch(0) !== 8'hC3 || qch(3) !== 8'hFF || ovr_active !== 4'b1000) begin
            errors++;
            $display("FAIL isolation: got q0=%h q3=%h act=%b expected q0=c3 q3=ff act=1000",
                     qch(0), qch(3), ovr_active);
        end
        ovr_req[3] = 1'b0;
        step();
        checks++;
        if (ovr_hold !== 4'b1010 || qch(3) !== 8'hFF) begin
            errors++;
            $display("FAIL hold3: got hold=%b q3=%h expected hold=1010 q3=ff", ovr_hold, qch(3));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (q !== 32'h0 || ovr_hold !== 4'b0000 || ovr_active !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: got q=%h hold=%b act=%b expected q=0 hold=0000 act=0000",
                     q, ovr_hold, ovr_active);
        end
    endtask

`ifdef OVR_DFF_CNT_EN
    task automatic test_counter();
        ovr_mode[1:0] = 2'b00;
        ovr_req[0] = 1'b1;
        for (int k = 0; k < 7; k++) step();
        ovr_req[0] = 1'b0;
        step();
        checks++;
        if (ovr_cnt[15:0] !== 16'd7 || ovr_hold[0] !== 1'b1) begin
            errors++;
            $display("FAIL cnt_first: got cnt=%0d hold=%b expected cnt=7 hold=1", ovr_cnt[15:0], ovr_hold[0]);
        end
        ovr_req[0] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        ovr_req[0] = 1'b0;
        step();
        checks++;
        if (ovr_cnt[15:0] !== 16'd10) begin
            errors++;
            $display("FAIL cnt_accum: got %0d expected %0d", ovr_cnt[15:0], 10);
        end
        en[0] = 1'b1;
        step();
        en[0] = 1'b0;
        checks++;
        if (ovr_cnt[15:0] !== 16'd10 || ovr_hold[0] !== 1'b0) begin
            errors++;
            $display("FAIL cnt_normal_hold: got cnt=%0d hold=%b expected cnt=10 hold=0", ovr_cnt[15:0], ovr_hold[0]);
        end
        ovr_req[0] = 1'b1;
        step();
        step();
        ovr_req[0] = 1'b0;
        checks++;
        if (ovr_cnt[15:0] !== 16'd1) begin
            errors++;
            $display("FAIL cnt_restart: got %0d expected %0d", ovr_cnt[15:0], 1);
        end
        step();
    endtask
`endif

    initial begin
        rst      = 1'b0;
        en       = '0;
        d        = '0;
        ovr_req  = '0;
        ovr_mode = '0;
        ovr_val  = '0;
        #2;
        test_reset();
        test_normal_capture();
        test_force_release();
        test_modes_priority();
        test_pulse();
        test_isolation_reset();
        test_freeze_from_normal();
`ifdef OVR_DFF_CNT_EN
        test_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
